contador_modulo_hex: RTL

//  Parametrised synchronous up/down modulo-N counter with load, wrap flag and multi-digit 7-seg output.

---
 rtl/contador_pkg.sv | 28 ++
 rtl/decodificador_hex7seg.sv | 15 +
 rtl/contador_modulo_hex.sv | 109 ++++++++++
 3 files changed

// File: rtl/contador_pkg.sv
// Shared types and the 7-segment glyph table for the modulo counter and its display decoder.
package contador_pkg;

    typedef logic [6:0] seg7_t;

    // Active-low segments, bit order {a,b,c,d,e,f,g} from MSB to LSB.
    localparam seg7_t SEG_GLYPH [0:15] = '{
        7'b0000001,  // 0
        7'b1001111,  // 1
        7'b0010010,  // 2
        7'b0000110,  // 3
        7'b1001100,  // 4
        7'b0100100,  // 5
        7'b0100000,  // 6
        7'b0001111,  // 7
        7'b0000000,  // 8
        7'b0000100,  // 9
        7'b0001000,  // A
        7'b1100000,  // b
        7'b0110001,  // C
        7'b1000010,  // d
        7'b0110000,  // E
        7'b0111000   // F
    };

    localparam seg7_t SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/decodificador_hex7seg.sv
// Hex nibble to active-low 7-segment decoder; purely combinational.
module decodificador_hex7seg
    import contador_pkg::*;
(
    input  logic [3:0] nibble,
    output seg7_t      seg
);

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        seg = SEG_BLANK;
        seg = SEG_GLYPH[nibble];
    end

endmodule

// File: rtl/contador_modulo_hex.sv
// Parametrised up/down modulo-MODULO counter with load, wrap flag and DIGITS-digit hex display.
// Define CONTADOR_STEP_EDGE_EN to count once per synchronised rising edge of step instead of per level.
module contador_modulo_hex
    import contador_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int MODULO = 8,
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  step,
    input  logic                  up,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    output logic [WIDTH-1:0]      count,
    output logic                  wrap,
    output logic [7*DIGITS-1:0]   hex
);

    localparam int NIB_W = 4 * DIGITS;

    // Widened by one bit so that MODULO == 2**WIDTH is still representable.
    localparam logic [WIDTH:0]   MOD_EXT   = (WIDTH+1)'(MODULO);
    localparam logic [WIDTH-1:0] COUNT_MAX = WIDTH'(MODULO - 1);

    if (MODULO < 2 || MODULO > (2 ** WIDTH)) begin : g_bad_modulo
        $error("contador_modulo_hex: MODULO=%0d outside 2..2**WIDTH", MODULO);
    end
    if (NIB_W < WIDTH) begin : g_bad_digits
        $error("contador_modulo_hex: DIGITS=%0d too few for WIDTH=%0d", DIGITS, WIDTH);
    end

    logic step_acc;

`ifdef CONTADOR_STEP_EDGE_EN
    logic s1, s2, s3;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= step;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // s3 advances even when load wins, so a step edge coinciding with load is dropped.
    assign step_acc = s2 & ~s3;
`else
    assign step_acc = step;
`endif

    logic [WIDTH-1:0] count_nxt;
    logic             wrap_nxt;

    always_comb begin
        count_nxt = count;
        wrap_nxt  = 1'b0;
        if (load) begin
            count_nxt = ({1'b0, load_val} < MOD_EXT) ? load_val : '0;
        end else if (step_acc) begin
            if (up) begin
                if (count == COUNT_MAX) begin
                    count_nxt = '0;
                    wrap_nxt  = 1'b1;
                end else begin
                    count_nxt = count + 1'b1;
                end
            end else begin
                if (count == '0) begin
                    count_nxt = COUNT_MAX;
                    wrap_nxt  = 1'b1;
                end else begin
                    count_nxt = count - 1'b1;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            count <= count_nxt;
            wrap  <= wrap_nxt;
        end
    end

    logic [NIB_W-1:0] count_ext;

    always_comb begin
        count_ext              = '0;
        count_ext[WIDTH-1:0]   = count;
    end

    for (genvar d = 0; d < DIGITS; d++) begin : g_digit
        decodificador_hex7seg u_dec (
            .nibble (count_ext[4*d +: 4]),
            .seg    (hex[7*d +: 7])
        );
    end

endmodule
